// File: rtl/div_frec_pkg.sv
// Shared defaults and constants for the programmable clock divider.
// Bounds come from the divider's legal operating range.
package div_frec_pkg;

  localparam int unsigned DEF_N   = 27;
  localparam int unsigned DEF_DIV = 100_000_000;
  localparam int unsigned MIN_DIV = 2;

  // A divisor below MIN_DIV cannot form a period with both a high and a low phase.
  function automatic logic div_is_valid(input logic [31:0] value);
    return (value >= 32'(MIN_DIV));
  endfunction

endpackage

// File: rtl/div_frec_prog.sv
// Programmable clock divider: N-bit period counter with a shadowed divisor
// that is applied only at period boundaries, plus a registered tick pulse.
module div_frec_prog
  import div_frec_pkg::*;
#(
  parameter int unsigned N           = DEF_N,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
)(
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync_clr,
  input  logic [N-1:0] div_val,
  input  logic         div_load,
  output logic         clk_out,
  output logic         tick,
  output logic         pend,
  output logic         err
);

  localparam logic [N-1:0] DIV_RST = N'(DEFAULT_DIV);
  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [N-1:0] ZERO    = N'(0);

  logic [N-1:0] cnt_r;
  logic [N-1:0] div_active_r;
  logic [N-1:0] div_shadow_r;
  logic         pend_r;
  logic         err_r;
  logic         tick_r;
  logic         clk_out_r;

  logic [N-1:0] cnt_s;
  logic [N-1:0] div_active_s;
  logic [N-1:0] div_shadow_s;
  logic         pend_s;
  logic         err_s;
  logic         tick_s;
  logic         clk_out_s;

  logic         terminal_s;
  logic         boundary_s;
  logic         load_ok_s;
  logic         load_bad_s;
  logic [N-1:0] half_s;

  // Decode period boundary and classify the divisor request.
  always_comb begin
    terminal_s = (cnt_r == (div_active_r - ONE));
    boundary_s = sync_clr | (en & terminal_s);
    load_ok_s  = div_load & div_is_valid(32'(div_val));
    load_bad_s = div_load & ~div_is_valid(32'(div_val));
    half_s     = div_active_r >> 1;
  end

  // Next-state for counter, divisor registers, flags and outputs.
  always_comb begin
    cnt_s        = cnt_r;
    div_active_s = div_active_r;
    div_shadow_s = div_shadow_r;
    pend_s       = pend_r;
    err_s        = err_r | load_bad_s;
    tick_s       = 1'b0;
    clk_out_s    = clk_out_r;

    if (sync_clr) begin
      cnt_s = ZERO;
    end else if (en) begin
      if (terminal_s) begin
        cnt_s = ZERO;
      end else begin
        cnt_s = cnt_r + ONE;
      end
    end else begin
      cnt_s = cnt_r;
    end

    if (sync_clr) begin
      tick_s = 1'b0;
    end else begin
      tick_s = en & terminal_s;
    end

    if (sync_clr | en) begin
      clk_out_s = (cnt_r < half_s);
    end else begin
      clk_out_s = clk_out_r;
    end

    if (load_ok_s) begin
      div_shadow_s = div_val;
    end else begin
      div_shadow_s = div_shadow_r;
    end

    // A load coinciding with a boundary bypasses the shadow and never pends.
    if (boundary_s) begin
      pend_s = 1'b0;
      if (load_ok_s) begin
        div_active_s = div_val;
      end else if (pend_r) begin
        div_active_s = div_shadow_r;
      end else begin
        div_active_s = div_active_r;
      end
    end else begin
      div_active_s = div_active_r;
      if (load_ok_s) begin
        pend_s = 1'b1;
      end else begin
        pend_s = pend_r;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_r        <= ZERO;
      div_active_r <= DIV_RST;
      div_shadow_r <= DIV_RST;
      pend_r       <= 1'b0;
      err_r        <= 1'b0;
      tick_r       <= 1'b0;
      clk_out_r    <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      div_active_r <= div_active_s;
      div_shadow_r <= div_shadow_s;
      pend_r       <= pend_s;
      err_r        <= err_s;
      tick_r       <= tick_s;
      clk_out_r    <= clk_out_s;
    end
  end

  assign clk_out = clk_out_r;
  assign tick    = tick_r;
  assign pend    = pend_r;
  assign err     = err_r;

endmodule
